// File: rtl/hs32_wb_master.sv
// ---------------------------------------------------------------------------
// hs32_wb_master
//
// Single-outstanding Wishbone classic (B3) initiator. A command taken on the
// valid/ready command channel becomes one Wishbone cycle. Its termination is
// returned on the valid/ready response channel as read data plus an error
// flag. Terminations are ack, err or, optionally, a timeout.
//
// Optional feature macro: HS32_WBM_TIMEOUT_EN
//   defined   - stb is force-terminated with an error after TIMEOUT cycles
//               without ack/err.
//   undefined - the bus phase waits indefinitely for ack/err.
//
// Ports
//   wb_clk_i, wb_rst_ni       clock, async-assert active-low reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_we/sel/adr/dat        command fields (write, byte lanes, addr, data)
//   rsp_valid/rsp_ready       response handshake
//   rsp_dat, rsp_err          read data (0 for writes/errors), error status
//   wbm_cyc_o..wbm_dat_o      Wishbone initiator outputs
//   wbm_dat_i/ack_i/err_i     Wishbone slave returns
//   busy                      high whenever a transfer/response is pending
// ---------------------------------------------------------------------------
module hs32_wb_master #(
    parameter int TIMEOUT = 255,
    parameter int TCNT_W  = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,

    output logic        busy
);

    // Elaboration-time guard on the timeout configuration.
    if (TIMEOUT < 1 || TIMEOUT > 65535 || (TIMEOUT >> TCNT_W) != 0) begin : g_param_check
        $error("hs32_wb_master: TIMEOUT must be 1..65535 and below 2**TCNT_W");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic   bus_term;    // slave terminated the cycle this edge
    logic   bus_tmo;     // timeout terminates the cycle this edge

    assign bus_term = wbm_ack_i | wbm_err_i;

`ifdef HS32_WBM_TIMEOUT_EN
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    logic [TCNT_W-1:0] tcnt;

    // Count reaches TIMEOUT on this edge; a real termination takes priority.
    assign bus_tmo = (tcnt == TCNT_LAST) && !bus_term;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tcnt <= '0;
        end else if (state == IDLE) begin
            tcnt <= '0;
        end else if (state == BUS && !bus_term) begin
            tcnt <= tcnt + 1'b1;
        end
    end
`else
    assign bus_tmo = 1'b0;
`endif

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid)            state_next = BUS;
            BUS:     if (bus_term || bus_tmo)  state_next = RESP;
            RESP:    if (rsp_ready)            state_next = IDLE;
            default:                           state_next = IDLE;
        endcase
    end

    // Registered bus and response outputs. The wbm_* command fields are only
    // loaded on acceptance and otherwise keep their last value.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= 32'h0;
            wbm_dat_o <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_dat   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= cmd_we;
                        wbm_sel_o <= cmd_sel;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                    end
                end
                BUS: begin
                    if (bus_term || bus_tmo) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_valid <= 1'b1;
                        // err beats a simultaneous ack; a timeout is an error.
                        rsp_err   <= wbm_err_i | bus_tmo;
                        rsp_dat   <= (!wbm_we_o && !wbm_err_i && wbm_ack_i) ? wbm_dat_i : 32'h0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
